chacha_bus_sequencer: RTL
=========================

// Module: chacha_bus_sequencer
// PURPOSE
//  Hardware bus initiator for the chacha20_poly1305_opt register interface (cs/we/address/write_data/read_data).
//  Takes a key, nonce and a stream of data words, then issues the register writes:
//  key 0x10-0x17, nonce 0x20-0x22, data 0x30+.
//  Then writes ctrl 0x08 = init, next, done, polls status 0x09 and returns the result.
//  Replaces CPU/testbench bus driving in the integrated memory-processing path.
// PARAMETERS
//  INIT_GAP    20  idle cycles after the init write, before the next write
//  NEXT_GAP    50  idle cycles after the next write, before the done write
//  POLL_MAX    64  max status reads before timeout
//  STATUS_MASK 32'h1  status bits; any set bit ends polling as complete
// PORTS
//  clk         in   1    clock, all logic on posedge
//  reset       in   1    synchronous, active-high
//  start       in   1    begin sequence (sampled in IDLE only)
//  key         in   256  captured at start
//  nonce       in   96   captured at start
//  num_words   in   5    data words to send; values >16 clamp to 16
//  data_valid  in   1    data_word valid
//  data_word   in   32   next data word
//  data_ready  out  1    word accepted when data_valid&&data_ready
//  busy        out  1    high from the cycle after start until done/error
//  done        out  1    one-cycle pulse, sequence complete
//  error       out  1    one-cycle pulse (coincident with done) on poll timeout
//  status      out  32   last status read; held until next start
//  cs          out  1    bus select
//  we          out  1    bus write enable
//  address     out  8    bus address
//  write_data  out  32   bus write data
//  read_data   in   32   bus read data, valid during cs&&!we cycle
// BEHAVIOUR
//  Reset: cs=we=0, address=0, write_data=0, busy=done=error=data_ready=0, status=0, state IDLE.
//  Reset mid-sequence aborts: next edge forces all of the above, no done pulse.
//  Bus transaction: cs=1 for exactly one cycle, always followed by >=1 cycle cs=0.
//   Write: cs=1, we=1 with address/write_data.
//   Read: cs=1, we=0; read_data captured on the edge ending that cycle.
//  Key/nonce order:
//   Key word i = key[255-32*i -: 32] to address 0x10+i, for i=0..7.
//   Nonce word j = nonce[95-32*j -: 32] to address 0x20+j.
//  Sequence/FSM: IDLE -> KEY(8 wr) -> NONCE(3 wr) -> DATA(n wr) -> INIT -> GAP1 -> NEXT -> GAP2 -> DONE_WR -> POLL -> FIN.
//  IDLE: start && !busy captures key, nonce and n=min(num_words,16); KEY begins next cycle.
//  DATA: data_ready=1 only in DATA idle cycles, while cs=0 and words remain.
//   An accepted word is written to 0x30+k on the following cycle (k=0..n-1).
//   data_valid low stalls with cs=0, no timeout.
//   n=0: DATA skipped entirely, data_ready never asserted.
//  Control writes: INIT writes 0x08 = 1; GAP1 waits INIT_GAP cycles.
//   NEXT writes 0x08 = 2; GAP2 waits NEXT_GAP cycles; DONE_WR writes 0x08 = 4.
//  POLL: reads 0x09 every 2 cycles.
//   (read_data & STATUS_MASK) != 0: latch status, go to FIN with error=0.
//   POLL_MAX reads without match: latch last status, go to FIN with error=1.
//  FIN: done=1 for one cycle (error with it if timed out), busy drops on the same edge, return to IDLE.
//  start while busy: ignored, no queuing.
//  start in the same cycle as FIN: ignored; a new start is required in IDLE.
//  Poll counter width: $clog2(POLL_MAX+1).
//  Gap counter sized for max(INIT_GAP, NEXT_GAP). Counters saturate, never wrap.
// TESTING
//  1 Reset: hold reset 3 cycles -> cs=we=0, busy=0, status=0; start during reset has no effect.
//  2 Key/nonce: key=00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_deadbeef_feedface, nonce=01010101_02020202_03030303, n=0
//    -> writes 0x10=00112233 ... 0x17=feedface, 0x20..0x22, then 0x08=1/2/4, with exact gaps checked.
//  3 Data: n=2 with words aaaaaaaa, bbbbbbbb, data_valid dropped for 5 cycles between them
//    -> 0x30=aaaaaaaa, 0x31=bbbbbbbb, cs=0 during the stall, exactly two data_ready handshakes.
//  4 Poll success: responder returns 0 for 3 reads then 00000001
//    -> exactly 4 reads of 0x09, done pulse, error=0, status=00000001.
//  5 Timeout: status always 0 -> exactly POLL_MAX reads, done=error=1 same cycle, busy low after.
//  6 Abort/ignore: start while busy -> no effect; reset asserted during GAP1 -> cs=0 next cycle, no done, fresh start works.

Source files
------------

// File: rtl/chacha_bus_sequencer.sv
// Bus initiator for the chacha20_poly1305 register block: loads key, nonce and data,
// pulses init/next/done through the control register, then polls status until set or timeout.
module chacha_bus_sequencer #(
  parameter int          INIT_GAP    = 20,
  parameter int          NEXT_GAP    = 50,
  parameter int          POLL_MAX    = 64,
  parameter logic [31:0] STATUS_MASK = 32'h1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [4:0]   num_words,
  input  logic         data_valid,
  input  logic [31:0]  data_word,
  output logic         data_ready,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [31:0]  status,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [31:0]  write_data,
  input  logic [31:0]  read_data
);
  localparam int GAP_MAX = (INIT_GAP > NEXT_GAP) ? INIT_GAP : NEXT_GAP;
  localparam int GW      = $clog2(GAP_MAX + 1);
  localparam int PW      = $clog2(POLL_MAX + 1);
  localparam logic [GW-1:0] G1_LAST = GW'(INIT_GAP - 1);
  localparam logic [GW-1:0] G2_LAST = GW'(NEXT_GAP - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(POLL_MAX - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_KEY, S_NONCE, S_DATA, S_INIT, S_GAP1, S_NEXT, S_GAP2, S_DONE_WR, S_POLL, S_FIN
  } state_t;

  state_t         state, state_nx;
  logic [255:0]   key_q, key_nx;
  logic [95:0]    nonce_q, nonce_nx;
  logic [4:0]     n_q, n_nx, idx_q, idx_nx;
  logic [GW-1:0]  gcnt, gcnt_nx;
  logic [PW-1:0]  pcnt, pcnt_nx;
  logic           cs_nx, we_nx, busy_nx, done_nx, error_nx;
  logic [7:0]     address_nx;
  logic [31:0]    write_data_nx, status_nx;

  always_ff @(posedge clk) begin
    key_q   <= key_nx;
    nonce_q <= nonce_nx;
    if (reset) begin
      state      <= S_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      gcnt       <= '0;
      pcnt       <= '0;
      cs         <= 1'b0;
      we         <= 1'b0;
      address    <= '0;
      write_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      status     <= '0;
    end else begin
      state      <= state_nx;
      n_q        <= n_nx;
      idx_q      <= idx_nx;
      gcnt       <= gcnt_nx;
      pcnt       <= pcnt_nx;
      cs         <= cs_nx;
      we         <= we_nx;
      address    <= address_nx;
      write_data <= write_data_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      error      <= error_nx;
      status     <= status_nx;
    end
  end

  // Every state issues at most one transaction and only from a cs=0 cycle,
  // so each bus cycle is always followed by at least one idle cycle.
  always_comb begin
    state_nx      = state;
    key_nx        = key_q;
    nonce_nx      = nonce_q;
    n_nx          = n_q;
    idx_nx        = idx_q;
    gcnt_nx       = gcnt;
    pcnt_nx       = pcnt;
    cs_nx         = 1'b0;
    we_nx         = 1'b0;
    address_nx    = address;
    write_data_nx = write_data;
    busy_nx       = busy;
    done_nx       = 1'b0;
    error_nx      = 1'b0;
    status_nx     = status;
    data_ready    = 1'b0;
    case (state)
      S_IDLE: if (start && !busy) begin
        key_nx    = key;
        nonce_nx  = nonce;
        n_nx      = (num_words > 5'd16) ? 5'd16 : num_words;
        idx_nx    = '0;
        busy_nx   = 1'b1;
        status_nx = '0;
        state_nx  = S_KEY;
      end
      S_KEY: if (!cs) begin
        cs_nx         = 1'b1;
        we_nx         = 1'b1;
        address_nx    = 8'h10 + {5'd0, idx_q[2:0]};
        write_data_nx = key_q[255:224];
        key_nx        = {key_q[223:0], 32'h0};
        if (idx_q == 5'd7) begin
          idx_nx   = '0;
          state_nx = S_NONCE;
        end else begin
          idx_nx = idx_q + 5'd1;
        end
      end
      S_NONCE: if (!cs) begin
        cs_nx         = 1'b1;
        we_nx         = 1'b1;
        address_nx    = 8'h20 + {6'd0, idx_q[1:0]};
        write_data_nx = nonce_q[95:64];
        nonce_nx      = {nonce_q[63:0], 32'h0};
        if (idx_q == 5'd2) begin
          idx_nx   = '0;
          state_nx = (n_q == 5'd0) ? S_INIT : S_DATA;
        end else begin
          idx_nx = idx_q + 5'd1;
        end
      end
      S_DATA: if (!cs) begin
        if (idx_q < n_q) begin
          data_ready = 1'b1;
          if (data_valid) begin
            cs_nx         = 1'b1;
            we_nx         = 1'b1;
            address_nx    = 8'h30 + {3'd0, idx_q};
            write_data_nx = data_word;
            idx_nx        = idx_q + 5'd1;
          end
        end else begin
          state_nx = S_INIT;
        end
      end
      S_INIT: if (!cs) begin
        cs_nx         = 1'b1;
        we_nx         = 1'b1;
        address_nx    = 8'h08;
        write_data_nx = 32'h1;
        gcnt_nx       = '0;
        state_nx      = S_GAP1;
      end
      S_GAP1: if (!cs) begin
        if (gcnt >= G1_LAST) begin
          cs_nx         = 1'b1;
          we_nx         = 1'b1;
          address_nx    = 8'h08;
          write_data_nx = 32'h2;
          state_nx      = S_NEXT;
        end else begin
          gcnt_nx = gcnt + 1'b1;
        end
      end
      S_NEXT: begin
        gcnt_nx  = '0;
        state_nx = S_GAP2;
      end
      S_GAP2: if (!cs) begin
        if (gcnt >= G2_LAST) begin
          cs_nx         = 1'b1;
          we_nx         = 1'b1;
          address_nx    = 8'h08;
          write_data_nx = 32'h4;
          state_nx      = S_DONE_WR;
        end else begin
          gcnt_nx = gcnt + 1'b1;
        end
      end
      S_DONE_WR: begin
        pcnt_nx  = '0;
        state_nx = S_POLL;
      end
      S_POLL: begin
        if (!cs) begin
          cs_nx      = 1'b1;
          address_nx = 8'h09;
        end else if ((read_data & STATUS_MASK) != 32'h0) begin
          status_nx = read_data;
          busy_nx   = 1'b0;
          done_nx   = 1'b1;
          state_nx  = S_FIN;
        end else if (pcnt >= P_LAST) begin
          status_nx = read_data;
          busy_nx   = 1'b0;
          done_nx   = 1'b1;
          error_nx  = 1'b1;
          state_nx  = S_FIN;
        end else begin
          pcnt_nx = pcnt + 1'b1;
        end
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
endmodule
